cmp_unit_pipe: RTL and testbench

- Second-generation comparator for the ALU datapath. It extends the 2-bit EQ/GT/LT compare unit with:
  - parametrised operand and result widths;
  - selectable signed or unsigned compare;
  - GE, NE, MIN and MAX functions;
  - a 2-stage valid/ready pipeline with backpressure;
  - saturating relation statistics counters.
- Sits between the operand register file and the ALU result mux, alongside the arithmetic and logic units.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/cmp_core.sv | 37 +++
 rtl/cmp_unit_pipe.sv | 161 ++++++++++++++++
 tb/tb_cmp_unit_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared function codes, legacy result codes and relation type for the
// pipelined comparator.
package cmp_pkg;

    localparam logic [2:0] FUN_NOP = 3'd0;
    localparam logic [2:0] FUN_EQ  = 3'd1;
    localparam logic [2:0] FUN_GT  = 3'd2;
    localparam logic [2:0] FUN_LT  = 3'd3;
    localparam logic [2:0] FUN_GE  = 3'd4;
    localparam logic [2:0] FUN_NE  = 3'd5;
    localparam logic [2:0] FUN_MIN = 3'd6;
    localparam logic [2:0] FUN_MAX = 3'd7;

    localparam logic [1:0] RES_FALSE = 2'd0;
    localparam logic [1:0] RES_EQ    = 2'd1;
    localparam logic [1:0] RES_GT    = 2'd2;
    localparam logic [1:0] RES_LT    = 2'd3;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } rel_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare with selectable two's-complement mode;
// produces the one-hot relation plus min/max of the operands.
module cmp_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_sel,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [WIDTH-1:0] min_v,
    output logic [WIDTH-1:0] max_v
);

    logic [WIDTH-1:0] a_key_s;
    logic [WIDTH-1:0] b_key_s;

    // Flipping the sign bit maps signed ordering onto unsigned ordering
    always_comb begin
        a_key_s            = a;
        b_key_s            = b;
        a_key_s[WIDTH-1]   = a[WIDTH-1] ^ signed_sel;
        b_key_s[WIDTH-1]   = b[WIDTH-1] ^ signed_sel;
        eq                 = (a == b);
        gt                 = (a_key_s > b_key_s);
        lt                 = !eq && !gt;
        if (gt) begin
            max_v = a;
            min_v = b;
        end else begin
            max_v = b;
            min_v = a;
        end
    end

endmodule

// File: rtl/cmp_unit_pipe.sv
// Two-stage valid/ready comparator: S1 holds raw compare results, S2 holds
// the formatted result; saturating per-relation statistics on output.
module cmp_unit_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = WIDTH,
    parameter bit SIGNED_EN = 1'b1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           ALU_FUN,
    input  logic                 SIGNED,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [OUT_WIDTH-1:0] CMP_OUT,
    output logic                 CMP_FLAG,
    input  logic                 OUT_READY,
    input  logic                 CLR_STATS,
    output logic [CNT_WIDTH-1:0] EQ_CNT,
    output logic [CNT_WIDTH-1:0] GT_CNT,
    output logic [CNT_WIDTH-1:0] LT_CNT
);

    localparam int XW = (OUT_WIDTH > WIDTH) ? OUT_WIDTH : WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Resize a min/max operand: sign- or zero-extend, or keep the LSBs
    function automatic logic [OUT_WIDTH-1:0] ext_res(input logic [WIDTH-1:0] v,
                                                     input logic sx);
        logic [XW-1:0] w;
        if (sx) begin
            w = XW'($signed(v));
        end else begin
            w = XW'(v);
        end
        return w[OUT_WIDTH-1:0];
    endfunction

    logic                 signed_eff_s;
    logic                 core_eq_s;
    logic                 core_gt_s;
    logic                 core_lt_s;
    logic [WIDTH-1:0]     core_min_s;
    logic [WIDTH-1:0]     core_max_s;
    logic                 s2_adv_s;
    logic                 in_ready_s;
    logic                 out_hs_s;
    logic [OUT_WIDTH-1:0] fmt_s;

    logic                 s1_valid_r;
    rel_t                 s1_rel_r;
    logic [WIDTH-1:0]     s1_min_r;
    logic [WIDTH-1:0]     s1_max_r;
    logic [2:0]           s1_fun_r;
    logic                 s1_signed_r;
    logic                 s2_valid_r;
    rel_t                 s2_rel_r;
    logic [OUT_WIDTH-1:0] s2_out_r;
    logic [CNT_WIDTH-1:0] eq_cnt_r;
    logic [CNT_WIDTH-1:0] gt_cnt_r;
    logic [CNT_WIDTH-1:0] lt_cnt_r;

    assign signed_eff_s = SIGNED & SIGNED_EN;
    assign s2_adv_s     = !s2_valid_r | OUT_READY;
    assign in_ready_s   = !s1_valid_r | s2_adv_s;
    assign out_hs_s     = s2_valid_r & OUT_READY;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a          (A),
        .b          (B),
        .signed_sel (signed_eff_s),
        .eq         (core_eq_s),
        .gt         (core_gt_s),
        .lt         (core_lt_s),
        .min_v      (core_min_s),
        .max_v      (core_max_s)
    );

    // S1: capture compare results whenever the stage can advance
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_r  <= 1'b0;
            s1_rel_r    <= '0;
            s1_min_r    <= '0;
            s1_max_r    <= '0;
            s1_fun_r    <= FUN_NOP;
            s1_signed_r <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r  <= IN_VALID;
            s1_rel_r    <= '{eq: core_eq_s, gt: core_gt_s, lt: core_lt_s};
            s1_min_r    <= core_min_s;
            s1_max_r    <= core_max_s;
            s1_fun_r    <= ALU_FUN;
            s1_signed_r <= signed_eff_s;
        end
    end

    // Result formatting from the S1 relation and selected function
    always_comb begin
        fmt_s = '0;
        case (s1_fun_r)
            FUN_NOP: fmt_s[1:0] = RES_FALSE;
            FUN_EQ:  fmt_s[1:0] = s1_rel_r.eq ? RES_EQ : RES_FALSE;
            FUN_GT:  fmt_s[1:0] = s1_rel_r.gt ? RES_GT : RES_FALSE;
            FUN_LT:  fmt_s[1:0] = s1_rel_r.lt ? RES_LT : RES_FALSE;
            FUN_GE:  fmt_s[1:0] = (s1_rel_r.gt | s1_rel_r.eq) ? RES_EQ : RES_FALSE;
            FUN_NE:  fmt_s[1:0] = !s1_rel_r.eq ? RES_EQ : RES_FALSE;
            FUN_MIN: fmt_s      = ext_res(s1_min_r, s1_signed_r);
            FUN_MAX: fmt_s      = ext_res(s1_max_r, s1_signed_r);
            default: fmt_s      = '0;
        endcase
    end

    // S2: output register, frozen while downstream stalls
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_valid_r <= 1'b0;
            s2_rel_r   <= '0;
            s2_out_r   <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            s2_rel_r   <= s1_rel_r;
            s2_out_r   <= fmt_s;
        end
    end

    // Statistics: clear wins over a coincident handshake; no wrap
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            eq_cnt_r <= '0;
            gt_cnt_r <= '0;
            lt_cnt_r <= '0;
        end else if (CLR_STATS) begin
            eq_cnt_r <= '0;
            gt_cnt_r <= '0;
            lt_cnt_r <= '0;
        end else if (out_hs_s) begin
            if (s2_rel_r.eq && (eq_cnt_r != CNT_MAX)) begin
                eq_cnt_r <= eq_cnt_r + CNT_WIDTH'(1);
            end
            if (s2_rel_r.gt && (gt_cnt_r != CNT_MAX)) begin
                gt_cnt_r <= gt_cnt_r + CNT_WIDTH'(1);
            end
            if (s2_rel_r.lt && (lt_cnt_r != CNT_MAX)) begin
                lt_cnt_r <= lt_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    assign IN_READY = in_ready_s;
    assign CMP_OUT  = s2_out_r;
    assign CMP_FLAG = s2_valid_r;
    assign EQ_CNT   = eq_cnt_r;
    assign GT_CNT   = gt_cnt_r;
    assign LT_CNT   = lt_cnt_r;

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// Self-checking bench for cmp_unit_pipe (WIDTH=16, OUT_WIDTH=20, CNT_WIDTH=2)
// against an arithmetic reference model with an in-flight transaction queue.
module tb_cmp_unit_pipe;

    typedef struct {
        logic [19:0] res;
        int          rel;   // 0 eq, 1 gt, 2 lt
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic [2:0]  fun = 3'd0;
    logic        sg = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] cmp_out;
    logic        cmp_flag;
    logic        out_ready = 1'b1;
    logic        clr = 1'b0;
    logic [1:0]  eq_cnt;
    logic [1:0]  gt_cnt;
    logic [1:0]  lt_cnt;

    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;
    bit          lat_chk = 1'b0;
    bit          prev_hold = 1'b0;
    logic [19:0] prev_out = 20'h0;
    bit          last_acc = 1'b0;
    int          m_cnt [3] = '{0, 0, 0};
    exp_t        q [$];
    logic [19:0] out_log [$];

    always #5 clk = ~clk;

    cmp_unit_pipe #(
        .WIDTH     (16),
        .OUT_WIDTH (20),
        .SIGNED_EN (1'b1),
        .CNT_WIDTH (2)
    ) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .A         (a),
        .B         (b),
        .ALU_FUN   (fun),
        .SIGNED    (sg),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .CMP_OUT   (cmp_out),
        .CMP_FLAG  (cmp_flag),
        .OUT_READY (out_ready),
        .CLR_STATS (clr),
        .EQ_CNT    (eq_cnt),
        .GT_CNT    (gt_cnt),
        .LT_CNT    (lt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: compare as plain integers, then pick the legacy code or value
    function automatic exp_t ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                       input logic [2:0] rf, input logic rs);
        exp_t e;
        int   x;
        int   y;
        int   m;
        x = rs ? int'($signed(ra)) : int'(ra);
        y = rs ? int'($signed(rb)) : int'(rb);
        e.rel = (x == y) ? 0 : ((x > y) ? 1 : 2);
        e.acc = 0;
        m = 0;
        case (rf)
            3'd1: m = (x == y) ? 1 : 0;
            3'd2: m = (x > y)  ? 2 : 0;
            3'd3: m = (x < y)  ? 3 : 0;
            3'd4: m = (x >= y) ? 1 : 0;
            3'd5: m = (x != y) ? 1 : 0;
            3'd6: m = (x < y)  ? x : y;
            3'd7: m = (x > y)  ? x : y;
            default: m = 0;
        endcase
        e.res = m[19:0];
        return e;
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, "_eq_cnt"}, {30'h0, eq_cnt}, m_cnt[0]);
        chk({tag, "_gt_cnt"}, {30'h0, gt_cnt}, m_cnt[1]);
        chk({tag, "_lt_cnt"}, {30'h0, lt_cnt}, m_cnt[2]);
    endtask

    // One clock: sample and check at negedge, update model at posedge
    task automatic step();
        exp_t e;
        bit   exp_rdy;
        bit   acc;
        bit   hs;
        @(negedge clk);
        exp_rdy = !(q.size() == 2 && !out_ready);
        acc = in_valid && exp_rdy;
        hs  = cmp_flag && out_ready;
        chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
        chk("flag_without_txn", {31'h0, (cmp_flag && q.size() == 0)}, 32'h0);
        if (prev_hold) begin
            chk("hold_flag", {31'h0, cmp_flag}, 32'h1);
            chk("hold_out", {12'h0, cmp_out}, {12'h0, prev_out});
        end
        if (hs && q.size() != 0) begin
            chk("result", {12'h0, cmp_out}, {12'h0, q[0].res});
            if (lat_chk) chk("latency", cyc_n - q[0].acc, 32'd2);
            out_log.push_back(cmp_out);
        end
        prev_hold = cmp_flag && !out_ready;
        prev_out  = cmp_out;
        @(posedge clk);
        if (hs && q.size() != 0) begin
            if (m_cnt[q[0].rel] < 3) m_cnt[q[0].rel]++;
            void'(q.pop_front());
        end
        if (clr) m_cnt = '{0, 0, 0};
        if (acc) begin
            e = ref_model(a, b, fun, sg);
            e.acc = cyc_n;
            q.push_back(e);
        end
        last_acc = acc;
        cyc_n++;
        #1;
        check_counters("cyc");
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12 && q.size() != 0; k++) step();
        step();
        chk("drain_empty", q.size(), 32'h0);
    endtask

    logic [19:0] codes_exp [8] = '{20'h0, 20'h0, 20'h2, 20'h0, 20'h1, 20'h1, 20'h3, 20'h5};
    logic [19:0] sgn_exp   [5] = '{20'h0, 20'h3, 20'hFFFFF, 20'h2, 20'h1};
    logic [2:0]  sgn_fun   [5] = '{3'd2, 3'd3, 3'd6, 3'd2, 3'd6};
    logic        sgn_sel   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int n_acc;

        // Reset state
        #2;
        chk("rst_flag", {31'h0, cmp_flag}, 32'h0);
        chk("rst_out", {12'h0, cmp_out}, 32'h0);
        chk("rst_ready", {31'h0, in_ready}, 32'h1);
        check_counters("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Unsigned codes, back-to-back, latency 2
        lat_chk = 1'b1;
        out_log.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = 16'h0005; b = 16'h0003; fun = 3'(i); sg = 1'b0;
            step();
        end
        drain();
        chk("codes_count", out_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("codes_value", {12'h0, out_log[i]}, {12'h0, codes_exp[i]});

        // Signed vs unsigned
        out_log.delete();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; fun = sgn_fun[i]; sg = sgn_sel[i];
            step();
        end
        drain();
        chk("sgn_count", out_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < out_log.size(); i++)
            chk("sgn_value", {12'h0, out_log[i]}, {12'h0, sgn_exp[i]});

        // Width extension of signed MAX
        out_log.delete();
        in_valid = 1'b1; a = 16'h8000; b = 16'h9000; fun = 3'd7; sg = 1'b1;
        step();
        drain();
        chk("wext_count", out_log.size(), 32'd1);
        if (out_log.size() != 0) chk("wext_value", {12'h0, out_log[0]}, 32'hF9000);
        lat_chk = 1'b0;

        // Backpressure: 4 transactions with OUT_READY low for 5 cycles
        out_log.delete();
        n_acc = 0;
        for (int k = 0; k < 30 && n_acc < 4; k++) begin
            out_ready = (k < 5) ? 1'b0 : 1'b1;
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            fun = 3'($urandom); sg = 1'($urandom);
            step();
            if (last_acc) n_acc++;
        end
        chk("bp_accepted", n_acc, 32'd4);
        drain();
        chk("bp_outputs", out_log.size(), 32'd4);

        // Statistics: saturation, then clear coincident with a GT handshake
        clr = 1'b1; in_valid = 1'b0; step(); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = a; fun = 3'($urandom); sg = 1'($urandom);
            step();
        end
        drain();
        chk("sat_eq", {30'h0, eq_cnt}, 32'd3);
        chk("sat_gt", {30'h0, gt_cnt}, 32'd0);
        chk("sat_lt", {30'h0, lt_cnt}, 32'd0);
        in_valid = 1'b1; a = 16'h0009; b = 16'h0002; fun = 3'd2; sg = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_eq", {30'h0, eq_cnt}, 32'd0);
        chk("clr_gt", {30'h0, gt_cnt}, 32'd0);
        chk("clr_lt", {30'h0, lt_cnt}, 32'd0);
        chk("clr_q_empty", q.size(), 32'h0);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            in_valid  = 1'($urandom);
            a         = 16'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            fun       = 3'($urandom);
            sg        = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 15) == 0);
            step();
        end
        clr = 1'b0;
        drain();

        // Reset mid-flight with both stages full
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 16'h0007; b = 16'h0007; fun = 3'd1; sg = 1'b0;
            step();
        end
        in_valid = 1'b0;
        chk("mid_q_full", q.size(), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flag", {31'h0, cmp_flag}, 32'h0);
        chk("mid_rst_out", {12'h0, cmp_out}, 32'h0);
        q.delete();
        m_cnt = '{0, 0, 0};
        prev_hold = 1'b0;
        check_counters("mid_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("post_rst_flag", {31'h0, cmp_flag}, 32'h0);
        chk("post_rst_ready", {31'h0, in_ready}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
